// File: rtl/gascon_round_sequencer.sv
// gascon_round_sequencer: multi-round controller for one single-round Gascon core.
// Accepts a state and round count, drives the core once per round (reset pulse,
// then enable until done), feeds each core result back, and returns the final state.
// Optional feature macro: GASCON_SEQ_WATCHDOG_EN adds a per-round watchdog that
// aborts to OUT and raises a sticky wd_error when the core never signals done.
module gascon_round_sequencer #(
    parameter int CWIDTH     = 320,
    parameter int RWIDTH     = 16,
    parameter int MAX_ROUNDS = 12,
    parameter int WD_LIMIT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CWIDTH-1:0] in_state,
    input  logic [3:0]        in_rounds,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] out_state,
    output logic              busy,
    output logic [CWIDTH-1:0] core_c,
    output logic [RWIDTH-1:0] core_round,
    output logic              core_reset,
    output logic              core_en,
    input  logic [CWIDTH-1:0] core_cout,
    input  logic              core_done,
    output logic              wd_error
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE_RST = 2'd1,
        ST_CORE_RUN = 2'd2,
        ST_OUT      = 2'd3
    } state_t;

    // Round indices run from MAX_ROUNDS-n up to MAX_ROUNDS-1, so 4 bits never wrap.
    localparam logic [3:0] MAX_R4  = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_R4 = 4'(MAX_ROUNDS - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [CWIDTH-1:0] state_reg_r;
    logic [CWIDTH-1:0] state_reg_next_s;
    logic [3:0]        round_ctr_r;
    logic [3:0]        round_ctr_next_s;
    logic [3:0]        n_rounds_s;
    logic              wd_trip_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              core_en_r;
    logic              core_reset_r;

    // Requested round count clamped to a full permutation.
    always_comb begin
        n_rounds_s = in_rounds;
        if (in_rounds > MAX_R4) begin
            n_rounds_s = MAX_R4;
        end else begin
            n_rounds_s = in_rounds;
        end
    end

    // Next-state, state-register and round-counter logic.
    always_comb begin
        state_next_s     = state_r;
        state_reg_next_s = state_reg_r;
        round_ctr_next_s = round_ctr_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_reg_next_s = in_state;
                    round_ctr_next_s = MAX_R4 - n_rounds_s;
                    if (n_rounds_s == 4'd0) begin
                        state_next_s = ST_OUT;
                    end else begin
                        state_next_s = ST_CORE_RST;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CORE_RST: begin
                state_next_s = ST_CORE_RUN;
            end
            ST_CORE_RUN: begin
                if (core_done) begin
                    state_reg_next_s = core_cout;
                    if (round_ctr_r == LAST_R4) begin
                        state_next_s = ST_OUT;
                    end else begin
                        round_ctr_next_s = round_ctr_r + 4'd1;
                        state_next_s     = ST_CORE_RST;
                    end
                end else if (wd_trip_s) begin
                    state_next_s = ST_OUT;
                end else begin
                    state_next_s = ST_CORE_RUN;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state
    // so they change on the same edge as the FSM and never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            state_reg_r  <= '0;
            round_ctr_r  <= 4'd0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            core_en_r    <= 1'b0;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            state_reg_r  <= state_reg_next_s;
            round_ctr_r  <= round_ctr_next_s;
            in_ready_r   <= (state_next_s == ST_IDLE);
            out_valid_r  <= (state_next_s == ST_OUT);
            busy_r       <= (state_next_s != ST_IDLE);
            core_en_r    <= (state_next_s == ST_CORE_RUN);
            core_reset_r <= (state_next_s != ST_CORE_RUN);
        end
    end

`ifdef GASCON_SEQ_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);

    logic [7:0] wd_cnt_r;
    logic       wd_error_r;

    assign wd_trip_s = (state_r == ST_CORE_RUN) && !core_done && (wd_cnt_r == WD_LAST);

    // Cycles spent waiting for core_done in the current round; cleared outside CORE_RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= 8'd0;
        end else if (state_r != ST_CORE_RUN) begin
            wd_cnt_r <= 8'd0;
        end else if (!core_done) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_error_r <= 1'b0;
        end else if (wd_trip_s) begin
            wd_error_r <= 1'b1;
        end else begin
            wd_error_r <= wd_error_r;
        end
    end

    assign wd_error = wd_error_r;
`else
    assign wd_trip_s = 1'b0;
    assign wd_error  = 1'b0;
`endif

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign core_en    = core_en_r;
    assign core_reset = core_reset_r;
    assign out_state  = state_reg_r;
    assign core_c     = state_reg_r;
    assign core_round = {{(RWIDTH-4){1'b0}}, round_ctr_r};

endmodule
